ifetch_queue: RTL and testbench

- Consumer side of the program counter's fetch-address output.
- Each cycle it samples the PC address, issues an instruction-memory read, and tracks in-flight reads in a fixed-latency shadow pipe.
- Returned instruction words are buffered in a FIFO and delivered to decode over a valid/ready handshake.
- It back-pressures the PC through pc_en and discards wrong-path fetches when a jump or branch redirect (flush) occurs.

---
 rtl/ifetch_queue.sv | 65 ++++++
 tb/tb_ifetch_queue.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ifetch_queue: issues imem reads from the PC, tracks them in a fixed-latency shadow pipe and buffers returned words for decode
module ifetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_en,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] count;
  logic [AW-1:0] rd, wr;
  logic [31:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] mem_a [DEPTH];
  logic [MEM_LAT-1:0] sv;
  logic [MEM_LAT:0] sv_n;
  logic [ADDR_W-1:0] sa [MEM_LAT];
  int unsigned outst;
  logic issue, push, pop;
  always_comb begin
    outst = 0;
    for (int i = 0; i < MEM_LAT; i++) outst = outst + 32'(sv[i]);
  end
  assign issue = !rst && !flush && ((32'(count) + outst) < DEPTH);
  assign sv_n = {sv, issue};
  assign push = !rst && !flush && sv[MEM_LAT-1];
  assign pop = instr_valid && instr_ready && !flush;
  assign pc_en = issue;
  assign imem_req = issue;
  assign imem_addr = issue ? pc_addr : '0;
  assign instr_valid = !rst && (count != '0);
  assign instr_data = instr_valid ? mem_d[rd] : '0;
  assign instr_pc = instr_valid ? mem_a[rd] : '0;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      rd <= '0;
      wr <= '0;
      sv <= '0;
    end else begin
      sv <= sv_n[MEM_LAT-1:0];
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
    end
  end
  always_ff @(posedge clk) begin
    sa[0] <= pc_addr;
    for (int i = MEM_LAT - 1; i > 0; i--) sa[i] <= sa[i-1];
    if (push) begin
      mem_d[wr] <= imem_rdata;
      mem_a[wr] <= sa[MEM_LAT-1];
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table-driven start-up vectors, hand-written flush/reset sequences and a randomized scoreboard run
module tb_ifetch_queue;
  localparam int DEPTH = 4, MEM_LAT = 2, ADDR_W = 32;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, instr_ready = 1'b0;
  logic [31:0] pc = '0, tgt = '0, imem_rdata;
  logic pc_en, imem_req, instr_valid;
  logic [31:0] imem_addr, instr_data, instr_pc;
  int checks = 0, errors = 0, delivered = 0;
  logic [31:0] exp_q [$];
  logic [MEM_LAT-1:0] mv = '0;
  logic [31:0] ma [MEM_LAT];
  typedef struct {
    logic r, f, rdy, v, en;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc), .pc_en(pc_en), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  always @(posedge clk) begin
    mv <= {mv[0], imem_req};
    ma[1] <= ma[0];
    ma[0] <= imem_addr;
    pc <= rst ? 32'h0 : flush ? tgt : pc_en ? pc + 32'd4 : pc;
  end
  assign imem_rdata = mv[1] ? (ma[1] ^ K) : 32'h0BAD0BAD;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic f, input logic rdy);
    @(negedge clk);
    rst = r;
    flush = f;
    instr_ready = rdy;
    #1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    chk("occupancy_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
    chk("pc_en_eq_req", 32'(pc_en), 32'(imem_req));
    if (rst || flush) exp_q.delete();
    else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) chk("spurious_delivery", instr_pc, 32'hFFFFFFFF);
        else begin
          e = exp_q.pop_front();
          chk("sb_pc", instr_pc, e);
          chk("sb_data", instr_data, e ^ K);
          delivered++;
        end
      end
      if (imem_req) begin
        chk("imem_addr", imem_addr, pc);
        exp_q.push_back(pc);
      end
    end
  end

  initial begin
    bit found;
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10}
    };
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_pc_en", i), 32'(pc_en), 32'(tbl[i].en));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_data", i), instr_data, tbl[i].pc ^ K);
      end
      if (tbl[i].r) begin
        chk($sformatf("tbl%0d_rst_addr", i), imem_addr, 32'h0);
        chk($sformatf("tbl%0d_rst_data", i), instr_data, 32'h0);
        chk($sformatf("tbl%0d_rst_req", i), 32'(imem_req), 32'h0);
      end
    end
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    tgt = 32'h100;
    cyc(1'b0, 1'b1, 1'b1);
    chk("flush_req", 32'(imem_req), 32'h0);
    chk("flush_pc_en", 32'(pc_en), 32'h0);
    chk("flush_head_present", 32'(instr_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("post_flush_valid", 32'(instr_valid), 32'h0);
    chk("post_flush_addr", imem_addr, 32'h100);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      found = instr_valid;
    end
    chk("post_flush_found", 32'(found), 32'h1);
    chk("post_flush_pc", instr_pc, 32'h100);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(instr_valid), 32'h0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      found = instr_valid;
    end
    chk("post_rst_found", 32'(found), 32'h1);
    chk("post_rst_pc", instr_pc, 32'h0);
    delivered = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        tgt = $urandom & 32'h0000FFFC;
        cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end else cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    chk("random_progress", 32'(delivered > 150), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
